// File: rtl/bcd_digit_packer.sv
// ---------------------------------------------------------------------------
// bcd_digit_packer
//
// Upstream stage of the 2-digit BCD-to-binary path. BCD digits arrive one at
// a time over a valid/ready stream. Each digit is range-checked, and the good
// ones are assembled into a {msd,lsd} pair. The pair is presented on a
// registered valid/ready output to the multiply-by-10 / add stage. Rejected
// digits (value > 9) raise a one-cycle err pulse and bump a saturating counter.
//
// Parameters
//   ERR_CNT_W     width of the saturating bad-digit counter
//   ABORT_ON_ERR  1: a bad digit discards a partial pair
//                 0: a bad digit is dropped and the partial pair is kept
//
// Compile-time option
//   BCD_PACKER_SKID_EN  when defined, a one-entry holding register follows the
//                       assembler. Assembly of the next pair can then continue
//                       while the consumer stalls. Pairs leave in order.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   clr          in   synchronous abort of any assembly in progress
//   digit        in   incoming BCD digit [3:0]
//   digit_last   in   with a first digit: single-digit entry (msd forced 0)
//   digit_valid  in   digit/digit_last valid
//   digit_ready  out  stage can accept a digit this cycle (combinational)
//   msd          out  tens digit of the presented pair [3:0]
//   lsd          out  units digit of the presented pair [3:0]
//   pair_valid   out  msd/lsd hold a complete pair (registered)
//   pair_ready   in   downstream accepts the pair
//   err          out  one-cycle pulse after a digit > 9 is accepted
//   err_cnt      out  saturating count of rejected digits [ERR_CNT_W-1:0]
// ---------------------------------------------------------------------------
module bcd_digit_packer #(
    parameter int ERR_CNT_W    = 8,
    parameter bit ABORT_ON_ERR = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [3:0]           digit,
    input  logic                 digit_last,
    input  logic                 digit_valid,
    output logic                 digit_ready,
    output logic [3:0]           msd,
    output logic [3:0]           lsd,
    output logic                 pair_valid,
    input  logic                 pair_ready,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HAVE_MSD = 2'd1,
        S_FULL     = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    state_t                w_state_eff;

    logic [3:0]            r_msd;
    logic [3:0]            r_lsd;
    logic                  r_err;
    logic [ERR_CNT_W-1:0]  r_err_cnt;

    logic                  w_bad;
    logic                  w_good;
    logic                  w_accept;
    logic                  w_xfer;
    logic                  w_asm_release;
    logic                  w_digit_ready;
    logic                  w_pair_valid;

`ifdef BCD_PACKER_SKID_EN
    logic                  r_hold_valid;
    logic [3:0]            r_hold_msd;
    logic [3:0]            r_hold_lsd;
`else
    logic                  r_pair_valid;
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Output / handshake decode
    // -----------------------------------------------------------------------
    always_comb begin
        w_bad  = (digit > 4'd9);
        w_good = ~w_bad;
`ifdef BCD_PACKER_SKID_EN
        // The assembler hands its pair to the holding register only when the
        // holding register is empty; until then it stays FULL.
        w_xfer        = r_hold_valid & pair_ready;
        w_asm_release = (r_state == S_FULL) & ~r_hold_valid;
        w_digit_ready = ~((r_state == S_FULL) & r_hold_valid) & ~clr;
        w_pair_valid  = r_hold_valid;
`else
        w_xfer        = r_pair_valid & pair_ready;
        w_asm_release = w_xfer;
        w_digit_ready = (r_state != S_FULL) & ~clr;
        w_pair_valid  = r_pair_valid;
`endif
        w_accept = digit_valid & w_digit_ready;
        // A FULL assembler that empties this cycle behaves as IDLE for the
        // incoming digit (only reachable with the holding register, since
        // digit_ready is low in FULL otherwise).
        if ((r_state == S_FULL) && w_asm_release) begin
            w_state_eff = S_IDLE;
        end else begin
            w_state_eff = r_state;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = w_state_eff;
        if (clr) begin
            w_state_next = S_IDLE;
        end else if (w_accept) begin
            case (w_state_eff)
                S_IDLE: begin
                    if (w_good) begin
                        w_state_next = digit_last ? S_FULL : S_HAVE_MSD;
                    end
                end
                S_HAVE_MSD: begin
                    if (w_good) begin
                        w_state_next = S_FULL;
                    end else if (ABORT_ON_ERR) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Digit capture: bad digits never reach msd/lsd
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msd <= 4'd0;
            r_lsd <= 4'd0;
        end else if (w_accept && w_good) begin
            case (w_state_eff)
                S_IDLE: begin
                    if (digit_last) begin
                        r_msd <= 4'd0;
                        r_lsd <= digit;
                    end else begin
                        r_msd <= digit;
                    end
                end
                S_HAVE_MSD: begin
                    r_lsd <= digit;
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Error pulse and saturating counter (clr does not touch the counter)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err <= w_accept & w_bad;
            if (w_accept && w_bad && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

`ifdef BCD_PACKER_SKID_EN
    // -----------------------------------------------------------------------
    // Holding register: takes a finished pair only when empty, so the pair
    // order is preserved and the data is stable while pair_valid is high.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_valid <= 1'b0;
            r_hold_msd   <= 4'd0;
            r_hold_lsd   <= 4'd0;
        end else if (clr) begin
            r_hold_valid <= 1'b0;
        end else if (w_asm_release) begin
            r_hold_valid <= 1'b1;
            r_hold_msd   <= r_msd;
            r_hold_lsd   <= r_lsd;
        end else if (w_xfer) begin
            r_hold_valid <= 1'b0;
        end
    end

    assign msd = r_hold_msd;
    assign lsd = r_hold_lsd;
`else
    // -----------------------------------------------------------------------
    // Registered pair_valid, mirrors the FULL state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pair_valid <= 1'b0;
        end else begin
            r_pair_valid <= (w_state_next == S_FULL);
        end
    end

    assign msd = r_msd;
    assign lsd = r_lsd;
`endif

    assign digit_ready = w_digit_ready;
    assign pair_valid  = w_pair_valid;
    assign err         = r_err;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_bcd_digit_packer.sv
// ---------------------------------------------------------------------------
// Testbench for bcd_digit_packer.
// dut : default parameters (ERR_CNT_W=8, ABORT_ON_ERR=1), pairs scored
//       through an expected-pair queue.
// dut2: ERR_CNT_W=2, ABORT_ON_ERR=0, checked directly.
// Inputs are driven 1 time unit after the rising edge; handshakes and pair
// transfers are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_bcd_digit_packer;

`ifdef BCD_PACKER_SKID_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst_n;

    logic       clr, digit_last, digit_valid, digit_ready;
    logic [3:0] digit, msd, lsd;
    logic       pair_valid, pair_ready, err;
    logic [7:0] err_cnt;

    logic       clr2, d2_last, d2_valid, d2_ready;
    logic [3:0] d2_digit, msd2, lsd2;
    logic       pv2, pr2, err2;
    logic [1:0] err_cnt2;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic       acc;
    logic       use2;
    logic [7:0] exp_q[$];

    bcd_digit_packer #(.ERR_CNT_W(8), .ABORT_ON_ERR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .digit(digit), .digit_last(digit_last), .digit_valid(digit_valid),
        .digit_ready(digit_ready), .msd(msd), .lsd(lsd),
        .pair_valid(pair_valid), .pair_ready(pair_ready),
        .err(err), .err_cnt(err_cnt)
    );

    bcd_digit_packer #(.ERR_CNT_W(2), .ABORT_ON_ERR(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr2),
        .digit(d2_digit), .digit_last(d2_last), .digit_valid(d2_valid),
        .digit_ready(d2_ready), .msd(msd2), .lsd(lsd2),
        .pair_valid(pv2), .pair_ready(pr2),
        .err(err2), .err_cnt(err_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, return 1 after the
    // next rising edge.
    task automatic cyc();
        logic [7:0] e;
        @(negedge clk);
        acc = use2 ? (d2_valid & d2_ready) : (digit_valid & digit_ready);
        if (pair_valid && pair_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pair", 32'({msd, lsd}), 32'h100);
            end else begin
                e = exp_q.pop_front();
                check("sb_pair", 32'({msd, lsd}), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Offer one digit until it is accepted (bounded).
    task automatic send(input logic [3:0] d, input logic last);
        int n;
        n = 0;
        if (use2) begin
            d2_digit = d; d2_last = last; d2_valid = 1'b1;
        end else begin
            digit = d; digit_last = last; digit_valid = 1'b1;
        end
        acc = 1'b0;
        while (!acc && n < 20) begin
            cyc();
            n++;
        end
        check("send_accept", 32'(acc), 32'd1);
        d2_valid    = 1'b0;
        digit_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] bad [5];
        int n;
        bad = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hF};
        use2 = 1'b0;
        acc  = 1'b0;
        rst_n = 1'b1;
        clr = 1'b0; digit = 4'd0; digit_last = 1'b0; digit_valid = 1'b0; pair_ready = 1'b0;
        clr2 = 1'b0; d2_digit = 4'd0; d2_last = 1'b0; d2_valid = 1'b0; pr2 = 1'b0;

        // Reset held, then released
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pair_valid", 32'(pair_valid), 32'd0);
        check("rst_msd",        32'(msd),        32'd0);
        check("rst_lsd",        32'(lsd),        32'd0);
        check("rst_err",        32'(err),        32'd0);
        check("rst_err_cnt",    32'(err_cnt),    32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_digit_ready", 32'(digit_ready), 32'd1);

        // Digits 4, 2
        pair_ready = 1'b1;
        send(4'd4, 1'b0);
        exp_q.push_back(8'h42);
        send(4'd2, 1'b0);
        repeat (LAT - 1) cyc();
        check("p42_valid", 32'(pair_valid), 32'd1);
        check("p42_msd",   32'(msd),        32'd4);
        check("p42_lsd",   32'(lsd),        32'd2);
        cyc();
        check("p42_valid_drop", 32'(pair_valid), 32'd0);
        check("p42_msd_keep",   32'(msd),        32'd4);

        // Single digit entry
        exp_q.push_back(8'h07);
        send(4'd7, 1'b1);
        repeat (LAT - 1) cyc();
        check("p07_valid", 32'(pair_valid), 32'd1);
        check("p07_msd",   32'(msd),        32'd0);
        check("p07_lsd",   32'(lsd),        32'd7);
        cyc();
        check("p07_valid_drop", 32'(pair_valid), 32'd0);

        // Bad digit aborts the partial pair
        send(4'd4, 1'b0);
        send(4'hB, 1'b0);
        check("bad_err_pulse", 32'(err),     32'd1);
        check("bad_err_cnt",   32'(err_cnt), 32'd1);
        cyc();
        check("bad_err_clear", 32'(err),     32'd0);
        send(4'd9, 1'b0);
        exp_q.push_back(8'h99);
        send(4'd9, 1'b0);
        repeat (LAT - 1) cyc();
        check("p99_valid", 32'(pair_valid), 32'd1);
        check("p99_lsd",   32'(lsd),        32'd9);
        cyc();

        // Back-pressure
        pair_ready = 1'b0;
        send(4'd3, 1'b0);
        exp_q.push_back(8'h35);
        send(4'd5, 1'b0);
        repeat (LAT - 1) cyc();
`ifdef BCD_PACKER_SKID_EN
        send(4'd1, 1'b0);
        exp_q.push_back(8'h16);
        send(4'd6, 1'b0);
`endif
        digit = 4'd1; digit_last = 1'b0; digit_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(pair_valid),  32'd1);
            check("stall_msd",   32'(msd),         32'd3);
            check("stall_lsd",   32'(lsd),         32'd5);
            check("stall_ready", 32'(digit_ready), 32'd0);
            cyc();
            check("stall_no_accept", 32'(acc), 32'd0);
        end
        digit_valid = 1'b0;
        pair_ready  = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            cyc();
            n++;
        end
        check("stall_drain", 32'(exp_q.size()), 32'd0);
        cyc();
        check("stall_after_valid", 32'(pair_valid), 32'd0);

        // clr in the same cycle as a transfer: transfer counts
        pair_ready = 1'b0;
        exp_q.push_back(8'h08);
        send(4'd8, 1'b1);
        repeat (LAT - 1) cyc();
        check("clrx_valid", 32'(pair_valid), 32'd1);
        pair_ready = 1'b1;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        check("clrx_valid_drop", 32'(pair_valid), 32'd0);

        // clr mid-pair
        send(4'd5, 1'b0);
        clr = 1'b1;
        #1;
        check("clr_ready_low", 32'(digit_ready), 32'd0);
        cyc();
        clr = 1'b0;
        check("clr_no_pair", 32'(pair_valid), 32'd0);
        exp_q.push_back(8'h06);
        send(4'd6, 1'b1);
        repeat (LAT - 1) cyc();
        check("p06_valid", 32'(pair_valid), 32'd1);
        check("p06_msd",   32'(msd),        32'd0);
        check("p06_lsd",   32'(lsd),        32'd6);
        cyc();
        check("err_cnt_kept", 32'(err_cnt), 32'd1);

        // Second instance: saturation and ABORT_ON_ERR=0
        use2 = 1'b1;
        pr2  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(bad[i], 1'b0);
            check("sat_err",     32'(err2),     32'd1);
            check("sat_err_cnt", 32'(err_cnt2), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        send(4'd2, 1'b0);
        send(4'hE, 1'b0);
        check("keep_err", 32'(err2), 32'd1);
        send(4'd3, 1'b0);
        repeat (LAT - 1) cyc();
        check("keep_valid", 32'(pv2),  32'd1);
        check("keep_msd",   32'(msd2), 32'd2);
        check("keep_lsd",   32'(lsd2), 32'd3);
        cyc();
        check("keep_valid_drop", 32'(pv2), 32'd0);
        send(4'd7, 1'b0);
        clr2 = 1'b1;
        cyc();
        clr2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("clr2_no_pair", 32'(pv2), 32'd0);
            cyc();
        end
        check("clr2_err_cnt", 32'(err_cnt2), 32'd3);
        send(4'd1, 1'b1);
        repeat (LAT - 1) cyc();
        check("p01_valid", 32'(pv2),  32'd1);
        check("p01_msd",   32'(msd2), 32'd0);
        check("p01_lsd",   32'(lsd2), 32'd1);
        cyc();
        use2 = 1'b0;

        // Reset mid-pair
        send(4'd3, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", 32'(pair_valid), 32'd0);
        check("rstmid_msd",   32'(msd),        32'd0);
        check("rstmid_cnt",   32'(err_cnt),    32'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        check("rstmid_ready", 32'(digit_ready), 32'd1);
        exp_q.push_back(8'h04);
        send(4'd4, 1'b1);
        repeat (LAT - 1) cyc();
        check("p04_valid", 32'(pair_valid), 32'd1);
        check("p04_msd",   32'(msd),        32'd0);
        cyc();
        check("p04_valid_drop", 32'(pair_valid), 32'd0);
        check("sb_empty_end",   32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
